// File: rtl/sub1_frame_packer.sv
// Byte-stream to 3-byte frame packer feeding sub1.
// Short frames (in_last or idle timeout) are padded with PAD_BYTE.
module sub1_frame_packer #(
    parameter logic [7:0]  PAD_BYTE       = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    input  logic            in_last,
    output logic            sig_a,
    output logic [1:0]      sig_b,
    output logic [0:2][7:0] sig_c,
    output logic [7:0]      sig_d [0:2],
    input  logic            out_ready
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    typedef enum logic {COLLECT, FULL} state_e;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [0:2][7:0] buf_q, buf_d;
    logic            sig_a_q, sig_a_d;
    logic [1:0]      sig_b_q, sig_b_d;
    logic [0:2][7:0] sig_c_q, sig_c_d;

    logic            collect;
    logic            accept;
    logic            tmo_fire;
    logic            done;
    logic            slot_free;
    logic            load;
    logic [1:0]      held;
    logic [0:2][7:0] lanes;
    logic [0:2][7:0] frame;

    always_comb begin
        collect   = (state_q == COLLECT);
        in_ready  = !rst && collect;
        accept    = in_valid && in_ready;
        slot_free = !sig_a_q || out_ready;
        held      = cnt_q + {1'b0, accept};

        lanes = buf_q;
        if (accept) begin
            lanes[cnt_q] = in_data;
        end

        // Lanes at or beyond the held count are filler, not stale data.
        for (int i = 0; i < 3; i++) begin
            frame[i] = (2'(i) < held) ? lanes[i] : PAD_BYTE;
        end

        // Fires on the edge that would bring the idle count to TIMEOUT_CYCLES.
        tmo_fire = (TIMEOUT_CYCLES != 0) && collect && (cnt_q != 2'd0)
                   && !accept && (32'(tcnt_q) == TIMEOUT_CYCLES - 1);
        done     = collect && ((accept && (cnt_q == 2'd2 || in_last)) || tmo_fire);

        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        buf_d   = lanes;
        sig_b_d = sig_b_q;
        sig_c_d = sig_c_q;
        load    = 1'b0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    cnt_d  = cnt_q + 2'd1;
                    tcnt_d = '0;
                end else if (cnt_q != 2'd0 && TIMEOUT_CYCLES != 0) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (done) begin
                    tcnt_d = '0;
                    if (slot_free) begin
                        load    = 1'b1;
                        sig_b_d = held;
                        sig_c_d = frame;
                        cnt_d   = 2'd0;
                    end else begin
                        buf_d   = frame;
                        cnt_d   = held;
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                tcnt_d = '0;
                if (out_ready) begin
                    load    = 1'b1;
                    sig_b_d = cnt_q;
                    sig_c_d = buf_q;
                    cnt_d   = 2'd0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        if (load) begin
            sig_a_d = 1'b1;
        end else if (sig_a_q && out_ready) begin
            sig_a_d = 1'b0;
        end else begin
            sig_a_d = sig_a_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            buf_q   <= '0;
            sig_a_q <= 1'b0;
            sig_b_q <= '0;
            sig_c_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            buf_q   <= buf_d;
            sig_a_q <= sig_a_d;
            sig_b_q <= sig_b_d;
            sig_c_q <= sig_c_d;
        end
    end

    always_comb begin
        sig_a = sig_a_q;
        sig_b = sig_b_q;
        sig_c = sig_c_q;
        for (int i = 0; i < 3; i++) begin
            sig_d[i] = sig_c_q[i];
        end
    end

endmodule

// File: tb/tb_sub1_frame_packer.sv
// Bench for sub1_frame_packer: directed scenarios plus a scoreboarded
// random back-pressure stream.
module tb_sub1_frame_packer;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic [7:0]      in_data = 8'h00;
    logic            in_last = 1'b0;
    logic            out_ready = 1'b0;
    logic            in_ready;
    logic            sig_a;
    logic [1:0]      sig_b;
    logic [0:2][7:0] sig_c;
    logic [7:0]      sig_d [0:2];

    logic            u1_in_ready;
    logic            u1_sig_a;
    logic [1:0]      u1_sig_b;
    logic [0:2][7:0] u1_sig_c;
    logic [7:0]      u1_sig_d [0:2];

    int checks = 0;
    int errors = 0;
    logic [25:0] sbq[$];

    always #5 clk = ~clk;

    sub1_frame_packer #(.PAD_BYTE(8'hEE), .TIMEOUT_CYCLES(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .sig_a(sig_a), .sig_b(sig_b),
        .sig_c(sig_c), .sig_d(sig_d), .out_ready(out_ready)
    );

    sub1_frame_packer #(.TIMEOUT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u1_in_ready),
        .in_data(in_data), .in_last(in_last), .sig_a(u1_sig_a), .sig_b(u1_sig_b),
        .sig_c(u1_sig_c), .sig_d(u1_sig_d), .out_ready(out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({sig_a, sig_b, sig_c} !== 27'd0) begin
            errors++;
            $display("FAIL reset_out got a=%b b=%0d c=%h exp 0", sig_a, sig_b, sig_c);
        end
        checks++;
        if ({sig_d[0], sig_d[1], sig_d[2]} !== 24'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_d_rdy got d=%h rdy=%b exp 0/0",
                     {sig_d[0], sig_d[1], sig_d[2]}, in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy got %b exp 1", in_ready);
        end
    endtask

    task automatic test_full_frame();
        out_ready = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        checks++;
        if (sig_a !== 1'b0) begin
            errors++;
            $display("FAIL t1_early_a got %b exp 0", sig_a);
        end
        send(8'h33, 1'b0);
        checks++;
        if (sig_a !== 1'b1 || sig_b !== 2'd3 || sig_c !== 24'h112233) begin
            errors++;
            $display("FAIL t1_frame got a=%b b=%0d c=%h exp 1/3/112233", sig_a, sig_b, sig_c);
        end
        checks++;
        if ({sig_d[0], sig_d[1], sig_d[2]} !== 24'h112233) begin
            errors++;
            $display("FAIL t1_sig_d got %h exp 112233", {sig_d[0], sig_d[1], sig_d[2]});
        end
    endtask

    task automatic test_last_pad();
        tick();
        checks++;
        if (sig_a !== 1'b0 || sig_c !== 24'h112233) begin
            errors++;
            $display("FAIL t2_drop got a=%b c=%h exp 0/112233", sig_a, sig_c);
        end
        send(8'hA5, 1'b1);
        checks++;
        if (sig_a !== 1'b1 || sig_b !== 2'd1 || sig_c !== 24'hA5EEEE) begin
            errors++;
            $display("FAIL t2_pad got a=%b b=%0d c=%h exp 1/1/a5eeee", sig_a, sig_b, sig_c);
        end
        // in_last without a handshake must be ignored
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        tick();
        checks++;
        if (sig_a !== 1'b0 || sig_c !== 24'hA5EEEE) begin
            errors++;
            $display("FAIL t2_stray_last got a=%b c=%h exp 0/a5eeee", sig_a, sig_c);
        end
    endtask

    task automatic test_backpressure();
        logic dropped;
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
        checks++;
        if (sig_a !== 1'b1 || sig_c !== 24'h010203 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL t3_full got a=%b c=%h rdy=%b exp 1/010203/0", sig_a, sig_c, in_ready);
        end
        tick();
        tick();
        checks++;
        if (sig_c !== 24'h010203 || sig_b !== 2'd3 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL t3_hold got c=%h b=%0d rdy=%b exp 010203/3/0", sig_c, sig_b, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        dropped = (sig_a !== 1'b1);
        checks++;
        if (dropped || sig_c !== 24'h040506 || sig_b !== 2'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL t3_swap got a=%b c=%h b=%0d rdy=%b exp 1/040506/3/1",
                     sig_a, sig_c, sig_b, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (sig_a !== 1'b0) begin
            errors++;
            $display("FAIL t3_drain got %b exp 0", sig_a);
        end
    endtask

    task automatic test_timeout();
        logic early;
        logic u1_fired;
        early = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) begin
                checks++;
                if (early) begin
                    errors++;
                    $display("FAIL t4_early got flush before 16 idle cycles exp none");
                end
            end
            tick();
            if (i < 16 && sig_a !== 1'b0) early = 1'b1;
        end
        checks++;
        if (sig_a !== 1'b1 || sig_b !== 2'd2 || sig_c !== 24'h0102EE) begin
            errors++;
            $display("FAIL t4_flush got a=%b b=%0d c=%h exp 1/2/0102ee", sig_a, sig_b, sig_c);
        end
        u1_fired = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (u1_sig_a !== 1'b0) u1_fired = 1'b1;
        end
        checks++;
        if (u1_fired) begin
            errors++;
            $display("FAIL t4_tmo_disabled got flush exp none");
        end
        checks++;
        if (sig_a !== 1'b0) begin
            errors++;
            $display("FAIL t4_empty_tmo got a=%b exp 0", sig_a);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(8'hAA, 1'b1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({sig_a, sig_b, sig_c} !== 27'd0 || {sig_d[0], sig_d[1], sig_d[2]} !== 24'd0) begin
            errors++;
            $display("FAIL t5_mid_rst got a=%b b=%0d c=%h exp 0", sig_a, sig_b, sig_c);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        send(8'h99, 1'b0);
        checks++;
        if (sig_a !== 1'b1 || sig_b !== 2'd3 || sig_c !== 24'h778899) begin
            errors++;
            $display("FAIL t5_fresh1 got a=%b b=%0d c=%h exp 1/3/778899", sig_a, sig_b, sig_c);
        end
        out_ready = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL t5_in_full got rdy=%b exp 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({sig_a, sig_b, sig_c} !== 27'd0 || {sig_d[0], sig_d[1], sig_d[2]} !== 24'd0) begin
            errors++;
            $display("FAIL t5_full_rst got a=%b b=%0d c=%h exp 0", sig_a, sig_b, sig_c);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        checks++;
        if (sig_a !== 1'b0) begin
            errors++;
            $display("FAIL t5_stale_full got a=%b exp 0", sig_a);
        end
        send(8'hC3, 1'b0);
        checks++;
        if (sig_a !== 1'b1 || sig_b !== 2'd3 || sig_c !== 24'hC1C2C3) begin
            errors++;
            $display("FAIL t5_fresh2 got a=%b b=%0d c=%h exp 1/3/c1c2c3", sig_a, sig_b, sig_c);
        end
    endtask

    task automatic test_back_to_back();
        logic stalled;
        stalled = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'h40 + 8'(i);
            @(negedge clk);
            if (in_ready !== 1'b1) stalled = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (stalled) begin
            errors++;
            $display("FAIL b2b_ready got in_ready drop exp none");
        end
        checks++;
        if (sig_a !== 1'b1 || sig_c !== 24'h464748) begin
            errors++;
            $display("FAIL b2b_last got a=%b c=%h exp 1/464748", sig_a, sig_c);
        end
        tick();
    endtask

    task automatic test_stream();
        int idx;
        int frames;
        int cyc;
        logic acc;
        logic [7:0] bytes [0:29];
        logic dmis;
        dmis = 1'b0;
        for (int i = 0; i < 30; i++) bytes[i] = 8'(i * 37 + 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idx = 0;
        frames = 0;
        cyc = 0;
        while ((idx < 30 || sbq.size() != 0 || sig_a) && cyc < 2000) begin
            if (idx < 30) begin
                in_valid = 1'b1;
                in_data = bytes[idx];
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            if ({sig_d[0], sig_d[1], sig_d[2]} !== sig_c) dmis = 1'b1;
            if (sig_a && out_ready) begin
                frames++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra got frame c=%h exp none", sig_c);
                end else if ({sig_b, sig_c} !== sbq[0]) begin
                    errors++;
                    $display("FAIL sb_frame got b=%0d c=%h exp b=%0d c=%h",
                             sig_b, sig_c, sbq[0][25:24], sbq[0][23:0]);
                    void'(sbq.pop_front());
                end else begin
                    void'(sbq.pop_front());
                end
            end
            acc = in_valid && in_ready;
            if (acc && (idx % 3) == 2) begin
                sbq.push_back({2'd3, bytes[idx-2], bytes[idx-1], bytes[idx]});
            end
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc >= 2000 || frames != 10 || sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_total got frames=%0d left=%0d cyc=%0d exp 10/0",
                     frames, sbq.size(), cyc);
        end
        checks++;
        if (dmis) begin
            errors++;
            $display("FAIL sb_sig_d got sig_d!=sig_c exp equal");
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_last_pad();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
